// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Imported by the memory, the interface users and the fetch top.
package instr_fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          IMEM_DEPTH = 64;
    localparam int          IMEM_AW    = 6;

    // One extra bit so the load pointer and program length can reach IMEM_DEPTH itself
    localparam int          LOAD_PTR_W = IMEM_AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Handshake and pipeline-register bundle between the fetch stage and its neighbours.
// The master side drives load/stall/branch controls; the slave side is the fetch stage.
interface instr_fetch_if;

    logic        LoadInstructions;
    logic [31:0] Instruction;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        LoadFull;

    modport master (
        output LoadInstructions, Instruction, Stall, BranchTaken, BranchTarget,
        input  IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, LoadFull
    );

    modport slave (
        input  LoadInstructions, Instruction, Stall, BranchTaken, BranchTarget,
        output IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, LoadFull
    );

endinterface

// File: rtl/instr_mem.sv
// 64 x 32 instruction memory: one synchronous write port, one combinational read port.
// Deliberately has no reset so a loaded program survives a pipeline reset.
module instr_mem
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [IMEM_AW-1:0] waddr,
    input  logic [31:0]        wdata,
    input  logic [IMEM_AW-1:0] raddr,
    output logic [31:0]        rdata
);

    logic [31:0] mem [IMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, program-load control and the IF/ID pipeline register.
// Priority is Reset > LoadInstructions > BranchTaken > Stall > normal fetch.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          Reset,
    instr_fetch_if.slave  bus
);

    logic [31:0]           pc_q, pc_d;
    logic [LOAD_PTR_W-1:0] load_ptr_q, load_ptr_d;
    logic [LOAD_PTR_W-1:0] prog_len_q = '0;
    logic [LOAD_PTR_W-1:0] prog_len_d;
    logic                  load_prev_q, load_prev_d;
    logic                  load_full_q, load_full_d;
    if_id_t                if_id_q, if_id_d;

    logic                  mem_we;
    logic [IMEM_AW-1:0]    mem_waddr;
    logic [31:0]           mem_rdata;
    logic                  fetch_hit;
    logic                  unused_target_lsbs;

    assign unused_target_lsbs = ^bus.BranchTarget[1:0];

    instr_mem u_instr_mem (
        .clk   (clk),
        .we    (mem_we & ~Reset),
        .waddr (mem_waddr),
        .wdata (bus.Instruction),
        .raddr (pc_q[IMEM_AW+1:2]),
        .rdata (mem_rdata)
    );

    // Whole word index is compared so addresses past the memory never alias back into it
    assign fetch_hit = {2'b00, pc_q[31:2]} < {{(32 - LOAD_PTR_W){1'b0}}, prog_len_q};

    always_comb begin
        pc_d        = pc_q;
        load_ptr_d  = load_ptr_q;
        prog_len_d  = prog_len_q;
        load_prev_d = bus.LoadInstructions;
        load_full_d = load_full_q;
        if_id_d     = if_id_q;
        mem_we      = 1'b0;
        mem_waddr   = load_ptr_q[IMEM_AW-1:0];

        if (bus.LoadInstructions) begin
            pc_d    = '0;
            if_id_d = '0;
            if (!load_prev_q) begin
                mem_we     = 1'b1;
                mem_waddr  = '0;
                load_ptr_d = LOAD_PTR_W'(1);
                prog_len_d = LOAD_PTR_W'(1);
            end else if (load_ptr_q == LOAD_PTR_W'(IMEM_DEPTH)) begin
                load_full_d = 1'b1;
            end else begin
                mem_we     = 1'b1;
                load_ptr_d = load_ptr_q + LOAD_PTR_W'(1);
                prog_len_d = prog_len_q + LOAD_PTR_W'(1);
            end
        end else if (bus.BranchTaken) begin
            pc_d    = {bus.BranchTarget[31:2], 2'b00};
            if_id_d = '0;
        end else if (!bus.Stall) begin
            if_id_d.instr    = fetch_hit ? mem_rdata : NOP_INSTR;
            if_id_d.pc_plus4 = pc_q + 32'd4;
            if_id_d.valid    = fetch_hit;
            pc_d             = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc_q        <= '0;
            load_ptr_q  <= '0;
            load_prev_q <= 1'b0;
            load_full_q <= 1'b0;
            if_id_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            load_ptr_q  <= load_ptr_d;
            load_prev_q <= load_prev_d;
            load_full_q <= load_full_d;
            if_id_q     <= if_id_d;
        end
    end

    // Program length survives reset so a loaded program can be rerun
    always_ff @(posedge clk) begin
        if (!Reset) begin
            prog_len_q <= prog_len_d;
        end
    end

    assign bus.IF_ID_Instr   = if_id_q.instr;
    assign bus.IF_ID_PCPlus4 = if_id_q.pc_plus4;
    assign bus.IF_ID_Valid   = if_id_q.valid;
    assign bus.LoadFull      = load_full_q;

endmodule
